// File: rtl/l2_spike_count_classifier.sv
// Layer-2 output classifier: counts spikes per neuron over a programmable window of
// timesteps, then serially picks the neuron with the most spikes (lowest index on ties).
module l2_spike_count_classifier #(
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              pulse,
    input  logic [N_OUT-1:0]  spk_in,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_id,
    output logic [CNT_W-1:0]  max_count
);

    typedef enum logic [1:0] {StIdle, StAccum, StScan, StDone} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q [N_OUT];
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [CNT_W-1:0]  best_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [IDX_W-1:0]  class_id_q;
    logic [CNT_W-1:0]  max_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            for (int i = 0; i < int'(N_OUT); i++) begin
                cnt_q[i] <= '0;
            end
            steps_q     <= '0;
            step_cnt_q  <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_id_q  <= '0;
            max_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        steps_q    <= num_steps;
                        step_cnt_q <= '0;
                        idx_q      <= '0;
                        for (int i = 0; i < int'(N_OUT); i++) begin
                            cnt_q[i] <= '0;
                        end
                        busy_q  <= 1'b1;
                        // A zero-length window skips accumulation and scans all-zero counts.
                        state_q <= (num_steps == '0) ? StScan : StAccum;
                    end
                end
                StAccum: begin
                    if (pulse) begin
                        for (int i = 0; i < int'(N_OUT); i++) begin
                            if (spk_in[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                        if (step_cnt_q == steps_q - STEP_W'(1)) begin
                            state_q <= StScan;
                        end
                    end
                end
                StScan: begin
                    // Strict compare keeps the lowest index on ties.
                    if ((idx_q == '0) || (cnt_q[idx_q] > best_cnt_q)) begin
                        best_cnt_q <= cnt_q[idx_q];
                        best_idx_q <= idx_q;
                    end
                    if (idx_q == IDX_W'(N_OUT - 1)) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    done_q      <= 1'b1;
                    class_id_q  <= best_idx_q;
                    max_count_q <= best_cnt_q;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign class_id  = class_id_q;
    assign max_count = max_count_q;

endmodule

// File: tb/tb_l2_spike_count_classifier.sv
// Bench for l2_spike_count_classifier: a timeline/argmax reference model checked every cycle,
// plus directed windows with hand-computed results.
module tb_l2_spike_count_classifier;

    localparam int N_OUT  = 10;
    localparam int CNT_W  = 8;
    localparam int STEP_W = 8;
    localparam int IDX_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic              pulse = 1'b0;
    logic [N_OUT-1:0]  spk_in = '0;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  class_id;
    logic [CNT_W-1:0]  max_count;

    int checks = 0;
    int failures = 0;

    l2_spike_count_classifier #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W),
        .STEP_W(STEP_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_steps(num_steps),
        .pulse    (pulse),
        .spk_in   (spk_in),
        .busy     (busy),
        .done     (done),
        .class_id (class_id),
        .max_count(max_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks a window as "pending" from accepted start until its done edge.
    int cyc = 0;
    int m_cnt [N_OUT];
    int m_steps, m_pulses, done_at, res_c, res_m;
    int start_cyc = 0, last_pulse_cyc = 0, done_seen_cyc = 0;
    bit m_pending = 0, m_accum = 0, m_busy = 0;
    int exp_busy = 0, exp_done = 0, exp_class = 0, exp_max = 0;

    task automatic finish_window();
        res_c = 0;
        res_m = m_cnt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (m_cnt[i] > res_m) begin
                res_m = m_cnt[i];
                res_c = i;
            end
        end
        done_at = cyc + N_OUT + 1;
    endtask

    always @(posedge clk or negedge reset) begin
        cyc++;
        if (!reset) begin
            m_pending = 0;
            m_accum   = 0;
            m_busy    = 0;
            exp_done  = 0;
            exp_class = 0;
            exp_max   = 0;
        end else begin
            exp_done = 0;
            if (!m_pending && start) begin
                for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
                m_steps   = int'(num_steps);
                m_pulses  = 0;
                m_pending = 1;
                m_busy    = 1;
                start_cyc = cyc;
                if (m_steps == 0) begin
                    m_accum = 0;
                    finish_window();
                end else begin
                    m_accum = 1;
                end
            end else if (m_accum && pulse) begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (spk_in[i] && m_cnt[i] < CMAX) m_cnt[i]++;
                end
                m_pulses++;
                if (m_pulses == m_steps) begin
                    m_accum = 0;
                    last_pulse_cyc = cyc;
                    finish_window();
                end
            end else if (m_pending && !m_accum) begin
                if (cyc == done_at - 1) m_busy = 0;
                if (cyc == done_at) begin
                    exp_done  = 1;
                    exp_class = res_c;
                    exp_max   = res_m;
                    m_pending = 0;
                end
            end
        end
        exp_busy = int'(m_busy);
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), exp_busy);
        chk("done", int'(done), exp_done);
        chk("class_id", int'(class_id), exp_class);
        chk("max_count", int'(max_count), exp_max);
        if (done) done_seen_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_window(input int steps, input int gap, input logic [N_OUT-1:0] base,
                             input logic [N_OUT-1:0] extra, input int n_extra,
                             input logic [N_OUT-1:0] off, input bit rnd, input bit start_in_gap);
        start     = 1'b1;
        num_steps = STEP_W'(steps);
        tick();
        start     = 1'b0;
        num_steps = STEP_W'($urandom);
        for (int p = 0; p < steps; p++) begin
            for (int g = 0; g < gap; g++) begin
                pulse  = 1'b0;
                spk_in = rnd ? N_OUT'($urandom) : off;
                start  = start_in_gap && (p == 1) && (g == 0);
                tick();
            end
            start  = 1'b0;
            pulse  = 1'b1;
            spk_in = rnd ? (N_OUT'($urandom) & N_OUT'($urandom)) : (base | ((p < n_extra) ? extra : '0));
            tick();
        end
        pulse  = 1'b0;
        spk_in = rnd ? N_OUT'($urandom) : off;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 2 * N_OUT + 5; k++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        repeat (3) tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_class", int'(class_id), 0);
        chk("idle_max", int'(max_count), 0);

        // Basic window: neuron 3 on all 5 pulses, neuron 7 on 2
        do_window(5, 0, 10'h008, 10'h080, 2, '0, 0, 0);
        wait_done();
        chk("basic_class", int'(class_id), 3);
        chk("basic_max", int'(max_count), 5);
        chk("basic_model_class", exp_class, 3);
        chk("basic_latency", done_seen_cyc - last_pulse_cyc, N_OUT + 1);

        // Saturation, then counters cleared between windows
        do_window(255, 0, 10'h001, '0, 0, '0, 0, 0);
        wait_done();
        chk("sat_max", int'(max_count), 255);
        chk("sat_model_max", exp_max, 255);
        do_window(200, 0, 10'h001, '0, 0, '0, 0, 0);
        wait_done();
        chk("sat2_max", int'(max_count), 200);
        chk("sat2_class", int'(class_id), 0);

        // Tie between 2 and 9 with gaps and noise on non-pulse cycles
        do_window(4, 3, 10'h204, '0, 0, 10'h3FF, 0, 0);
        wait_done();
        chk("tie_class", int'(class_id), 2);
        chk("tie_max", int'(max_count), 4);

        // Zero-length window
        do_window(0, 0, '0, '0, 0, '0, 0, 0);
        wait_done();
        chk("zero_class", int'(class_id), 0);
        chk("zero_max", int'(max_count), 0);
        chk("zero_latency", done_seen_cyc - start_cyc, N_OUT + 1);

        // Start pulsed during accumulation is ignored
        do_window(3, 2, 10'h040, '0, 0, '0, 0, 1);
        wait_done();
        chk("ign_class", int'(class_id), 6);
        chk("ign_max", int'(max_count), 3);
        chk("ign_latency", done_seen_cyc - last_pulse_cyc, N_OUT + 1);

        // Reset during scan of a window neuron 5 would win
        do_window(3, 0, 10'h020, '0, 0, '0, 0, 0);
        repeat (4) tick();
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_class", int'(class_id), 0);
        chk("mid_reset_max", int'(max_count), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("post_reset_class", int'(class_id), 0);
        do_window(4, 1, 10'h100, '0, 0, 10'h0FF, 0, 0);
        wait_done();
        chk("recover_class", int'(class_id), 8);
        chk("recover_max", int'(max_count), 4);

        // Randomized windows checked by the model
        for (int w = 0; w < 12; w++) begin
            do_window(int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), '0, '0, 0, '0,
                      1, bit'($urandom_range(0, 1)));
            wait_done();
            repeat (int'($urandom_range(0, 3))) tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_spike_count_classifier.md
Name: l2_spike_count_classifier

Overview:
- Downstream consumer of the layer-2 MAC+NCHU neuron array.
- Collects the N_OUT output spike lines over a programmable number of timesteps and counts spikes per neuron.
- After the window closes, runs a serial argmax over the counts.
- Reports the winning class index and its spike count with a one-cycle done strobe.

Parameters:
- N_OUT, 10, number of layer-2 output neurons / classes
- CNT_W, 8, width of each per-neuron spike counter (saturating)
- STEP_W, 8, width of the timestep window length
- IDX_W, 4, width of class index; must satisfy 2^IDX_W >= N_OUT

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  begin a new classification window; sampled only in IDLE
- num_steps  in  STEP_W  window length in timesteps; latched on accepted start
- pulse  in  1  timestep strobe, same signal that drives the NCHU stages
- spk_in  in  N_OUT  spike outputs of the layer-2 neurons, bit i = neuron i
- busy  out  1  high in ACCUM and SCAN
- done  out  1  one-cycle strobe when the result is valid
- class_id  out  IDX_W  winning neuron index
- max_count  out  CNT_W  spike count of the winner

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All counters, step_cnt, scan index and internal best registers go to 0.
  - busy=0, done=0, class_id=0, max_count=0.
  - Reset asserted mid-window or mid-scan aborts the operation; no done is produced.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - On start=1, latch num_steps into steps_q, clear all N_OUT counters and step_cnt.
  - Go to ACCUM, or go directly to SCAN if num_steps==0. In the zero case all counts are 0, giving class_id=0 and max_count=0.
  - class_id/max_count keep their previous result until the next DONE.
- ACCUM:
  - Work is done only on cycles with pulse=1. On such a cycle, for each i with spk_in[i]=1, cnt[i] increments.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - step_cnt increments on every pulse.
  - When pulse=1 and step_cnt==steps_q-1, that pulse's spikes are counted and the next state is SCAN.
  - spk_in is ignored on pulse=0 cycles.
- SCAN:
  - One neuron per cycle, idx 0..N_OUT-1.
  - At idx 0, best_cnt<=cnt[0] and best_idx<=0.
  - Thereafter, update only if cnt[idx] > best_cnt (strict), so ties resolve to the lowest index.
  - SCAN lasts exactly N_OUT cycles.
- DONE:
  - One cycle. Drive done=1 and register class_id<=best_idx and max_count<=best_cnt. Return to IDLE.
  - These outputs then hold until the next DONE or reset.
- Latency: done is high N_OUT+1 cycles after the clock edge that sampled the final pulse.
- Ignored inputs:
  - start is ignored outside IDLE, including the DONE cycle.
  - pulse and spk_in are ignored outside ACCUM.
  - start and the final pulse never coincide in a way that matters, because start is only honoured in IDLE.
- Arithmetic: all counts are unsigned. Comparisons are unsigned, full CNT_W width.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with no start. Required: busy=0, done=0, class_id=0, max_count=0 indefinitely.
- Basic window: num_steps=5, start. Across 5 pulses, drive neuron 3 spiking on all 5 and neuron 7 on 2, others 0. Required: done exactly 11 cycles (N_OUT+1) after the edge sampling the 5th pulse, with class_id=3 and max_count=5.
- Tie and gaps: num_steps=4, with pulses separated by 3 idle cycles each. spk_in held 0x204 (neurons 2 and 9) on pulse cycles and 0x3FF on non-pulse cycles. Required: class_id=2, max_count=4; the non-pulse spikes are not counted.
- Saturation: CNT_W=8, num_steps=255, then a second window with num_steps=200. Neuron 0 spikes every pulse in both windows. Required: max_count=255, then 200; the counter is cleared between windows and no wrap occurs.
- Zero window and ignored start: num_steps=0, start. Required: done after N_OUT+1 cycles with class_id=0, max_count=0. A start pulsed during ACCUM of a following 3-step window does not restart it; its result is unchanged.
- Mid-operation reset: assert reset during SCAN of a window where neuron 5 would win. Required: immediate busy=0, class_id=0, max_count=0, and no done. A new window then completes correctly.
